// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU codes, opcodes,
// funct codes, FSM state numbers and datapath mux select values.
package mips_pkg;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_XOR   = 3'd2;
    localparam logic [2:0] ALU_SLT   = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_ERROR = 3'd5;
    localparam logic [2:0] ALU_NOR   = 3'd6;
    localparam logic [2:0] ALU_OR    = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REX    = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_funct_decoder.sv
// Combinational R-type funct to ALU control decode; unknown funct yields
// ALU_ERROR with legal deasserted. Zero latency, no flow control.
module mips_funct_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       legal
);

    always_comb begin
        alu_ctl = ALU_ERROR;
        legal   = 1'b1;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_XOR:  alu_ctl = ALU_XOR;
            FN_NOR:  alu_ctl = ALU_NOR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects; stalls in FETCH/MEMRD/MEMWR until mem_ready.
module mips_control_fsm
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctl,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] state_q, state_d;
    logic [5:0] opcode_q, funct_q;
    logic [5:0] dec_funct;
    logic [2:0] dec_alu_ctl;
    logic       dec_legal;

    logic mem_read_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    logic pc_en_raw, illegal_raw;

    // DECODE judges the live instruction register; later states use the copy.
    assign dec_funct = (state_q == S_DECODE) ? funct : funct_q;

    mips_funct_decoder u_funct_dec (
        .funct   (dec_funct),
        .alu_ctl (dec_alu_ctl),
        .legal   (dec_legal)
    );

    always_comb begin
        state_d       = S_FETCH;
        iord          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_ctl       = ALU_ADD;
        pc_src        = PCSRC_ALU;
        pc_en_raw     = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                ir_write_raw = mem_ready;
                pc_en_raw    = mem_ready;
                state_d      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (dec_legal) state_d = S_REX;
                        else           illegal_raw = 1'b1;
                    end
                    default:        illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord         = 1'b1;
                mem_read_raw = 1'b1;
                state_d      = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_ctl   = dec_alu_ctl;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
                alu_ctl       = dec_alu_ctl;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_en_raw = (opcode_q == OP_BNE) ? ~zero : zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: reg_write_raw = 1'b1;
            S_JUMP: begin
                pc_src    = PCSRC_JUMP;
                pc_en_raw = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= OP_RTYPE;
            funct_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
                funct_q  <= funct;
            end
        end
    end

    // Reset must never let a write or request escape, whatever state is held.
    assign mem_read  = mem_read_raw  & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign ir_write  = ir_write_raw  & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign pc_en     = pc_en_raw     & ~reset;
    assign illegal   = illegal_raw   & ~reset;
    assign state     = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Randomized bench: each instruction's expected state path is derived from its
// class, stretched by memory waits, and every cycle's outputs are compared.
module tb_mips_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b1;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctl;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    logic rdy_q[$];
    int   zero_force = -1;
    int   last_cycles, last_irw;

    always #5 clk = ~clk;

    mips_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctl(alu_ctl), .pc_src(pc_src), .pc_en(pc_en), .illegal(illegal),
        .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'd0;
            6'h22: return 3'd1;
            6'h24: return 3'd4;
            6'h25: return 3'd7;
            6'h26: return 3'd2;
            6'h27: return 3'd6;
            6'h2A: return 3'd3;
            default: return 3'd5;
        endcase
    endfunction

    // Expected outputs in the order {iord,mr,mw,irw,rd,m2r,rw,sa,sb,ac,ps,pe,il}.
    function automatic logic [16:0] exp_out(input int st, input logic rdy, input logic z,
                                            input logic [5:0] op, input logic [5:0] fn,
                                            input logic ill);
        logic io, mr, mw, irw, rd, m2r, rw, sa, pe, il;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {io, mr, mw, irw, rd, m2r, rw, sa, pe, il} = '0;
        sb = 0; ps = 0; ac = 0;
        case (st)
            0:  begin mr = 1; sb = 1; irw = rdy; pe = rdy; end
            1:  begin sb = 3; il = ill; end
            2:  begin sa = 1; sb = 2; end
            3:  begin io = 1; mr = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; ac = alu_of(fn); end
            7:  begin rd = 1; rw = 1; ac = alu_of(fn); end
            8:  begin sa = 1; ac = 1; ps = 1; pe = (op == 6'h05) ? ~z : z; end
            9:  begin sa = 1; sb = 2; end
            10: rw = 1;
            11: begin ps = 2; pe = 1; end
            default: ;
        endcase
        return {io, mr, mw, irw, rd, m2r, rw, sa, sb, ac, ps, pe, il};
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            mem_ready = 1'b1;
            #1;
            check("reset_enables",
                  {pc_en, ir_write, mem_read, mem_write, reg_write, illegal}, 0);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
        int path[$];
        int idx, cyc, irw, st;
        logic ill, rdy, z;
        case (op)
            6'h00:        path = (alu_of(fn) != 3'd5) ? '{0, 1, 6, 7} : '{0, 1};
            6'h23:        path = '{0, 1, 2, 3, 4};
            6'h2B:        path = '{0, 1, 2, 5};
            6'h04, 6'h05: path = '{0, 1, 8};
            6'h08:        path = '{0, 1, 9, 10};
            6'h02:        path = '{0, 1, 11};
            default:      path = '{0, 1};
        endcase
        ill = (path.size() == 2);
        idx = 0; cyc = 0; irw = 0;
        while (idx < path.size()) begin
            if (cyc >= 100) begin
                check("cycle_budget", cyc, 100 - 1);
                break;
            end
            @(negedge clk);
            reset = 1'b0;
            st = path[idx];
            rdy = (rdy_q.size() != 0) ? rdy_q.pop_front() : ($urandom_range(0, 3) != 0);
            z = (zero_force >= 0) ? zero_force[0] : 1'($urandom);
            mem_ready = rdy;
            zero = z;
            // Past DECODE the IR contents are scrambled; the FSM must use its copy.
            opcode = (st <= 1) ? op : 6'($urandom);
            funct  = (st <= 1) ? fn : 6'($urandom);
            #1;
            check("state", state, st);
            check($sformatf("outs_s%0d", st),
                  {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_ctl, pc_src, pc_en, illegal},
                  exp_out(st, rdy, z, op, fn, ill));
            irw += ir_write;
            cyc++;
            if (st == abort_at) begin
                do_reset(2);
                break;
            end
            if (!((st == 0 || st == 3 || st == 5) && !rdy)) idx++;
        end
        last_cycles = cyc;
        last_irw = irw;
    endtask

    initial begin
        logic [5:0] ops [9];
        logic [5:0] fns [8];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h21};

        do_reset(3);

        rdy_q = '{1, 1, 1, 1};
        run_instr(6'h00, 6'h20, -1);
        check("add_cycles", last_cycles, 4);
        rdy_q = '{1, 1, 1, 1};
        run_instr(6'h00, 6'h2A, -1);

        rdy_q = '{0, 0, 1, 1, 1, 0, 1, 1};
        run_instr(6'h23, 6'h00, -1);
        check("lw_cycles", last_cycles, 8);
        check("lw_ir_write_once", last_irw, 1);

        for (int b = 0; b < 4; b++) begin
            zero_force = b & 1;
            rdy_q = '{1, 1, 1};
            run_instr((b < 2) ? 6'h04 : 6'h05, 6'h00, -1);
            check("branch_cycles", last_cycles, 3);
        end
        zero_force = -1;

        rdy_q = '{1, 1, 1, 0, 0, 1};
        run_instr(6'h2B, 6'h00, -1);
        check("sw_cycles", last_cycles, 6);

        rdy_q = '{1, 1};
        run_instr(6'h3F, 6'h00, -1);
        check("illegal_op_cycles", last_cycles, 2);
        rdy_q = '{1, 1};
        run_instr(6'h00, 6'h21, -1);
        check("illegal_fn_cycles", last_cycles, 2);

        rdy_q = '{1, 1, 1, 0};
        run_instr(6'h2B, 6'h00, 5);

        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            if ($urandom_range(0, 19) == 0) begin
                run_instr(op, fn, $urandom_range(0, 3));
            end else begin
                run_instr(op, fn, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
